// File: rtl/fsm_interface.sv
// fsm_interface: bus-side control FSM for the AES-128 block.
// Decodes host transfers into message/key shift strobes, pulses load,
// then strobes the output register during readback.
// Ports: clk, reset (async, active-low), CS, RW, adress (bus cycle);
//        load, shift_in_message, shift_in_key, shift_out (controls).
module fsm_interface #(
  parameter int NBYTES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic CS,
  input  logic RW,
  input  logic adress,
  output logic load,
  output logic shift_in_message,
  output logic shift_in_key,
  output logic shift_out
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] msg_cnt_q, msg_cnt_d;
  logic [CW-1:0] key_cnt_q, key_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;

  logic wr_xfer;
  logic rd_xfer;

  // Strobes are Mealy, so gate them with reset to keep them
  // low while reset is held even if the host is driving a cycle.
  assign wr_xfer = reset & CS & RW;
  assign rd_xfer = reset & CS & ~RW;

  always_comb begin
    state_d          = state_q;
    msg_cnt_d        = msg_cnt_q;
    key_cnt_d        = key_cnt_q;
    rd_cnt_d         = rd_cnt_q;
    shift_in_message = 1'b0;
    shift_in_key     = 1'b0;
    shift_out        = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (wr_xfer && !adress && msg_cnt_q != FULL) begin
          shift_in_message = 1'b1;
          msg_cnt_d        = msg_cnt_q + 1'b1;
        end
        if (wr_xfer && adress && key_cnt_q != FULL) begin
          shift_in_key = 1'b1;
          key_cnt_d    = key_cnt_q + 1'b1;
        end
        // Uses the updated counts so the final write moves to LOAD.
        if (msg_cnt_d == FULL && key_cnt_d == FULL) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        msg_cnt_d = '0;
        key_cnt_d = '0;
        rd_cnt_d  = '0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (rd_xfer) begin
          shift_out = 1'b1;
          if (rd_cnt_q == LAST) begin
            rd_cnt_d = '0;
            state_d  = S_COLLECT;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_COLLECT;
      msg_cnt_q <= '0;
      key_cnt_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      msg_cnt_q <= msg_cnt_d;
      key_cnt_q <= key_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign load = (state_q == S_LOAD);

endmodule

// File: tb/tb_fsm_interface.sv
// tb_fsm_interface: directed plus random bus traffic against a
// count-based model of the collect/load/readback protocol.
module tb_fsm_interface;

  localparam int NB = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic CS = 1'b0;
  logic RW = 1'b0;
  logic adress = 1'b0;
  logic load;
  logic shift_in_message;
  logic shift_in_key;
  logic shift_out;

  int checks = 0;
  int failures = 0;

  // model: phase 0 = collecting, 1 = load cycle, 2 = readback
  int phase = 0;
  int m_cnt = 0;
  int k_cnt = 0;
  int r_cnt = 0;

  int n_sim = 0;
  int n_sik = 0;
  int n_so = 0;
  int n_ld = 0;

  fsm_interface #(.NBYTES(NB)) dut (
    .clk              (clk),
    .reset            (reset),
    .CS               (CS),
    .RW               (RW),
    .adress           (adress),
    .load             (load),
    .shift_in_message (shift_in_message),
    .shift_in_key     (shift_in_key),
    .shift_out        (shift_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_load"}, int'(load), 0);
    check({tag, "_sim"}, int'(shift_in_message), 0);
    check({tag, "_sik"}, int'(shift_in_key), 0);
    check({tag, "_so"}, int'(shift_out), 0);
  endtask

  task automatic step(input bit c, input bit r, input bit a);
    bit e_ld, e_sm, e_sk, e_so;
    CS = c;
    RW = r;
    adress = a;
    #1;
    e_ld = (phase == 1);
    e_sm = (phase == 0) && c && r && !a && (m_cnt < NB);
    e_sk = (phase == 0) && c && r && a && (k_cnt < NB);
    e_so = (phase == 2) && c && !r;
    check("load", int'(load), int'(e_ld));
    check("shift_in_message", int'(shift_in_message), int'(e_sm));
    check("shift_in_key", int'(shift_in_key), int'(e_sk));
    check("shift_out", int'(shift_out), int'(e_so));
    n_sim += int'(shift_in_message);
    n_sik += int'(shift_in_key);
    n_so += int'(shift_out);
    n_ld += int'(load);
    @(posedge clk);
    #1;
    case (phase)
      0: begin
        if (e_sm) m_cnt++;
        if (e_sk) k_cnt++;
        if (m_cnt == NB && k_cnt == NB) phase = 1;
      end
      1: begin
        m_cnt = 0;
        k_cnt = 0;
        r_cnt = 0;
        phase = 2;
      end
      default: begin
        if (e_so) begin
          r_cnt++;
          if (r_cnt == NB) begin
            r_cnt = 0;
            phase = 0;
          end
        end
      end
    endcase
  endtask

  task automatic do_reset();
    CS = 1'b1;
    RW = 1'b1;
    adress = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_quiet("rst_async");
    @(negedge clk);
    check_quiet("rst_hold");
    reset = 1'b1;
    phase = 0;
    m_cnt = 0;
    k_cnt = 0;
    r_cnt = 0;
  endtask

  task automatic zero_counts();
    n_sim = 0;
    n_sik = 0;
    n_so = 0;
    n_ld = 0;
  endtask

  initial begin
    // reset held with a write driven on the bus
    CS = 1'b1;
    RW = 1'b1;
    #3;
    check_quiet("rst_init");
    @(negedge clk);
    check_quiet("rst_init2");
    reset = 1'b1;
    step(0, 1, 0);
    step(0, 0, 1);

    // 16 message then 16 key writes, load, readback
    zero_counts();
    for (int i = 0; i < NB; i++) step(1, 1, 0);
    for (int i = 0; i < NB; i++) step(1, 1, 1);
    step(0, 0, 0);
    check("seq_sim_cnt", n_sim, NB);
    check("seq_sik_cnt", n_sik, NB);
    check("seq_load_cnt", n_ld, 1);
    // writes in OUT are ignored
    step(1, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < NB; i++) step(1, 0, 0);
    check("rd_so_cnt", n_so, NB);
    step(1, 0, 0);
    check("rd_17th_so_cnt", n_so, NB);

    // over-write of message register
    zero_counts();
    for (int i = 0; i < NB + 2; i++) step(1, 1, 0);
    check("ovw_sim_cnt", n_sim, NB);
    check("ovw_no_load", n_ld, 0);
    for (int i = 0; i < NB; i++) step(1, 1, 1);
    step(0, 1, 0);
    check("ovw_load_cnt", n_ld, 1);
    for (int i = 0; i < NB; i++) step(1, 0, 1);

    // interleaved with idle gaps
    zero_counts();
    for (int i = 0; i < NB; i++) begin
      step(1, 1, 0);
      step(0, 1, 1);
      step(1, 1, 1);
      step(0, 0, 0);
    end
    check("ilv_sim_cnt", n_sim, NB);
    check("ilv_sik_cnt", n_sik, NB);
    check("ilv_load_cnt", n_ld, 1);
    for (int i = 0; i < NB; i++) step(1, 0, 0);

    // abort after 10 key writes
    zero_counts();
    for (int i = 0; i < 10; i++) step(1, 1, 1);
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < NB; i++) step(1, 1, 0);
    for (int i = 0; i < NB - 1; i++) step(1, 1, 1);
    step(0, 0, 0);
    check("abort_no_load", n_ld, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    check("abort_load", n_ld, 1);
    for (int i = 0; i < NB; i++) step(1, 0, 0);

    // random traffic, writes favoured to reach readback often
    for (int i = 0; i < 3000; i++) begin
      bit c, r, a;
      c = ($urandom_range(0, 3) != 0);
      r = (phase == 2) ? ($urandom_range(0, 3) == 0)
                       : ($urandom_range(0, 4) != 0);
      a = $urandom_range(0, 1) != 0;
      step(c, r, a);
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
